// File: rtl/nibble_seq_adder.sv
// Sequential W-bit adder that walks the operands one nibble per two cycles
// through an external registered 4-bit adder slice, rippling the carry between nibbles.
module nibble_seq_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic [3:0]             x_nib,
    output logic [3:0]             y_nib,
    output logic                   c_nib,
    output logic                   add_en,
    input  logic [3:0]             r_nib,
    input  logic                   cout_nib,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q;
    logic            cin_q;
    logic            carry_q;
    logic [KW-1:0]   k_q;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            ovf_q;
    logic [KW+1:0]   base;

    assign base = {k_q, 2'b00};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (k_q == K_LAST) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        x_nib  = '0;
        y_nib  = '0;
        c_nib  = 1'b0;
        add_en = 1'b0;
        busy   = (state_q == ISSUE) || (state_q == WAIT);
        done   = (state_q == DONE);
        if (state_q == ISSUE) begin
            x_nib  = a_q[base +: 4];
            y_nib  = b_q[base +: 4];
            c_nib  = (k_q == '0) ? cin_q : carry_q;
            add_en = 1'b1;
        end
    end

    // Partial result with the slice output merged in, used for the final capture
    always_comb begin
        res_d = res_q;
        res_d[base +: 4] = r_nib;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        cin_q <= cin;
                        k_q   <= '0;
                    end
                end
                WAIT: begin
                    res_q   <= res_d;
                    carry_q <= cout_nib;
                    if (k_q == K_LAST) begin
                        sum_q  <= res_d;
                        cout_q <= cout_nib;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
